// File: rtl/mtimer_multi_if.sv
// Bus bundle for the machine-timer peripheral: CPU-side access signals plus
// the per-channel interrupt outputs.
interface mtimer_multi_if #(
    parameter int unsigned NUM_TIMERS = 2
);
    logic [31:0]           address_in;
    logic                  sel_in;
    logic                  read_in;
    logic [3:0]            write_mask_in;
    logic [31:0]           write_value_in;
    logic [31:0]           read_value_out;
    logic                  ready_out;
    logic [NUM_TIMERS-1:0] timer_irq_out;
    logic [NUM_TIMERS-1:0] soft_irq_out;

    modport master (
        output address_in, sel_in, read_in, write_mask_in, write_value_in,
        input  read_value_out, ready_out, timer_irq_out, soft_irq_out
    );

    modport slave (
        input  address_in, sel_in, read_in, write_mask_in, write_value_in,
        output read_value_out, ready_out, timer_irq_out, soft_irq_out
    );
endinterface

// File: rtl/mtimer_multi.sv
// Machine timer: prescaled free-running 64-bit mtime, NUM_TIMERS compare
// channels with level interrupts, and per-channel software interrupt bits.
module mtimer_multi #(
    parameter int unsigned NUM_TIMERS = 2,
    parameter int unsigned PRESCALE   = 1,
    parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input logic          clk,
    input logic          reset_n,
    mtimer_multi_if.slave bus
);

    localparam int unsigned PW = 16;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]         pcnt;
    logic [63:0]           mtime;
    logic                  enable;
    logic [NUM_TIMERS-1:0] msip;
    logic [63:0]           cmp [NUM_TIMERS];
    logic                  ready;
    logic [31:0]           read_value;
    logic [NUM_TIMERS-1:0] timer_irq;

    logic [5:0]  word;
    logic        wr;
    logic        rd;
    logic        tick;
    logic [31:0] rdata_c;
    logic        unused_addr;

    assign word        = bus.address_in[7:2];
    assign unused_addr = ^{bus.address_in[31:8], bus.address_in[1:0]};
    assign wr          = bus.sel_in && (bus.write_mask_in != 4'b0000);
    assign rd          = bus.sel_in && bus.read_in;
    assign tick        = enable && (pcnt == PS_LAST);

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  mask);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = mask[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return res;
    endfunction

    // Prescaler, mtime and control registers; a bus write to mtime beats a tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt   <= '0;
            mtime  <= '0;
            enable <= 1'b1;
            msip   <= '0;
        end else begin
            if (enable) begin
                pcnt <= (pcnt == PS_LAST) ? '0 : pcnt + PW'(1);
            end
            if (wr && (word == 6'd0)) begin
                mtime[31:0] <= merge(mtime[31:0], bus.write_value_in, bus.write_mask_in);
            end else if (wr && (word == 6'd1)) begin
                mtime[63:32] <= merge(mtime[63:32], bus.write_value_in, bus.write_mask_in);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
            if (wr && (word == 6'd2) && bus.write_mask_in[0]) begin
                enable <= bus.write_value_in[0];
            end
            if (wr && (word == 6'd3) && bus.write_mask_in[0]) begin
                msip <= bus.write_value_in[NUM_TIMERS-1:0];
            end
        end
    end

    // Compare registers, two words per channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                cmp[i] <= CMP_RESET;
            end
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (wr && (word == 6'(4 + 2 * i))) begin
                    cmp[i][31:0] <= merge(cmp[i][31:0], bus.write_value_in, bus.write_mask_in);
                end
                if (wr && (word == 6'(5 + 2 * i))) begin
                    cmp[i][63:32] <= merge(cmp[i][63:32], bus.write_value_in, bus.write_mask_in);
                end
            end
        end
    end

    // Read mux over pre-update register values.
    always_comb begin
        rdata_c = '0;
        case (word)
            6'd0:    rdata_c = mtime[31:0];
            6'd1:    rdata_c = mtime[63:32];
            6'd2:    rdata_c = 32'(enable);
            6'd3:    rdata_c = 32'(msip);
            default: begin
                for (int i = 0; i < NUM_TIMERS; i++) begin
                    if (word == 6'(4 + 2 * i)) rdata_c = cmp[i][31:0];
                    if (word == 6'(5 + 2 * i)) rdata_c = cmp[i][63:32];
                end
            end
        endcase
    end

    // Registered acknowledge, read data and timer interrupts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready      <= 1'b0;
            read_value <= '0;
            timer_irq  <= '0;
        end else begin
            ready      <= bus.sel_in;
            read_value <= rd ? rdata_c : 32'h0;
            for (int i = 0; i < NUM_TIMERS; i++) begin
                timer_irq[i] <= (mtime >= cmp[i]);
            end
        end
    end

    assign bus.ready_out      = ready;
    assign bus.read_value_out = read_value;
    assign bus.timer_irq_out  = timer_irq;
    assign bus.soft_irq_out   = msip;

endmodule

// File: tb/tb_mtimer_multi.sv
// Bench for mtimer_multi: two instances (prescale 1 and 4) driven in lockstep
// and compared every cycle against a behavioural model, plus directed checks.
module tb_mtimer_multi;

    localparam int unsigned NT = 2;

    logic        clk;
    logic        reset_n;
    logic        t_sel;
    logic        t_read;
    logic [31:0] t_addr;
    logic [3:0]  t_mask;
    logic [31:0] t_data;

    int n_cmp;
    int n_fail;

    logic [31:0] r1;
    logic [31:0] r4;
    logic [63:0] frozen1;
    logic [63:0] frozen4;

    mtimer_multi_if #(.NUM_TIMERS(NT)) b1 ();
    mtimer_multi_if #(.NUM_TIMERS(NT)) b4 ();

    assign b1.sel_in         = t_sel;
    assign b1.read_in        = t_read;
    assign b1.address_in     = t_addr;
    assign b1.write_mask_in  = t_mask;
    assign b1.write_value_in = t_data;
    assign b4.sel_in         = t_sel;
    assign b4.read_in        = t_read;
    assign b4.address_in     = t_addr;
    assign b4.write_mask_in  = t_mask;
    assign b4.write_value_in = t_data;

    mtimer_multi #(.NUM_TIMERS(NT), .PRESCALE(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    mtimer_multi #(.NUM_TIMERS(NT), .PRESCALE(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference state, one entry per instance.
    logic [63:0]   m_time [2];
    int unsigned   m_pc   [2];
    logic          m_en   [2];
    logic [63:0]   m_cmp  [2][NT];
    logic [NT-1:0] m_msip [2];
    logic          e_ready [2];
    logic [31:0]   e_rdata [2];
    logic [NT-1:0] e_tirq  [2];

    function automatic int unsigned ps_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] v,
                                        input logic [3:0] m);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = v[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int d, input int w);
        if (w == 0) return m_time[d][31:0];
        if (w == 1) return m_time[d][63:32];
        if (w == 2) return {31'b0, m_en[d]};
        if (w == 3) return 32'(m_msip[d]);
        if (w >= 4 && w < 4 + 2 * NT) begin
            if (w % 2 == 1) return m_cmp[d][(w - 4) / 2][63:32];
            return m_cmp[d][(w - 4) / 2][31:0];
        end
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_time[d]  = 64'h0;
            m_pc[d]    = 0;
            m_en[d]    = 1'b1;
            m_msip[d]  = '0;
            e_ready[d] = 1'b0;
            e_rdata[d] = 32'h0;
            e_tirq[d]  = '0;
            for (int i = 0; i < NT; i++) m_cmp[d][i] = 64'hFFFF_FFFF_FFFF_FFFF;
        end
    endtask

    task automatic model_step();
        int   w;
        logic wr;
        logic tick;
        w  = int'(t_addr[7:2]);
        wr = t_sel && (t_mask != 4'b0000);
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                e_ready[d] = t_sel;
                e_rdata[d] = (t_sel && t_read) ? m_read(d, w) : 32'h0;
                for (int i = 0; i < NT; i++) e_tirq[d][i] = (m_time[d] >= m_cmp[d][i]);
                tick = m_en[d] && (m_pc[d] == ps_of(d) - 1);
                if (m_en[d]) m_pc[d] = (m_pc[d] + 1) % ps_of(d);
                if (wr && w == 0)      m_time[d][31:0]  = mrg(m_time[d][31:0], t_data, t_mask);
                else if (wr && w == 1) m_time[d][63:32] = mrg(m_time[d][63:32], t_data, t_mask);
                else if (tick)         m_time[d] = m_time[d] + 64'd1;
                if (wr && w == 2 && t_mask[0]) m_en[d] = t_data[0];
                if (wr && w == 3 && t_mask[0]) m_msip[d] = t_data[NT-1:0];
                for (int i = 0; i < NT; i++) begin
                    if (wr && w == 4 + 2 * i) m_cmp[d][i][31:0]  = mrg(m_cmp[d][i][31:0], t_data, t_mask);
                    if (wr && w == 5 + 2 * i) m_cmp[d][i][63:32] = mrg(m_cmp[d][i][63:32], t_data, t_mask);
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ready_p1", 64'(b1.ready_out), 64'(e_ready[0]));
        chk("rdata_p1", 64'(b1.read_value_out), 64'(e_rdata[0]));
        chk("tirq_p1",  64'(b1.timer_irq_out), 64'(e_tirq[0]));
        chk("sirq_p1",  64'(b1.soft_irq_out), 64'(m_msip[0]));
        chk("ready_p4", 64'(b4.ready_out), 64'(e_ready[1]));
        chk("rdata_p4", 64'(b4.read_value_out), 64'(e_rdata[1]));
        chk("tirq_p4",  64'(b4.timer_irq_out), 64'(e_tirq[1]));
        chk("sirq_p4",  64'(b4.soft_irq_out), 64'(m_msip[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wr_word(input logic [5:0] w, input logic [3:0] m, input logic [31:0] v);
        logic [31:0] r;
        r      = $urandom();
        t_addr = {r[31:8], w, r[1:0]};
        t_sel  = 1'b1;
        t_read = 1'b0;
        t_mask = m;
        t_data = v;
        step();
        t_sel  = 1'b0;
        t_mask = 4'b0000;
    endtask

    task automatic rd_word(input logic [5:0] w);
        logic [31:0] r;
        r      = $urandom();
        t_addr = {r[31:8], w, r[1:0]};
        t_sel  = 1'b1;
        t_read = 1'b1;
        t_mask = 4'b0000;
        step();
        r1     = b1.read_value_out;
        r4     = b4.read_value_out;
        t_sel  = 1'b0;
        t_read = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd;
        n_cmp   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        t_sel   = 1'b0;
        t_read  = 1'b0;
        t_addr  = 32'h0;
        t_mask  = 4'b0000;
        t_data  = 32'h0;
        model_reset();
        #1;
        check_all();
        idle(3);
        reset_n = 1'b1;

        // Free run after reset.
        idle(10);
        rd_word(6'd0);
        chk("mtimel_after_10", 64'(r1), 64'd10);
        rd_word(6'd1);
        chk("mtimeh_after_10", 64'(r1), 64'd0);

        // Prescaled advance and freeze.
        wr_word(6'd2, 4'b0001, 32'h0);
        wr_word(6'd0, 4'b1111, 32'h0);
        wr_word(6'd1, 4'b1111, 32'h0);
        wr_word(6'd2, 4'b0001, 32'h1);
        idle(16);
        rd_word(6'd0);
        chk("ps4_advance_16", 64'(r4), 64'd4);
        chk("ps1_advance_16", 64'(r1), 64'd16);
        wr_word(6'd2, 4'b0001, 32'h0);
        frozen1 = m_time[0];
        frozen4 = m_time[1];
        idle(20);
        rd_word(6'd0);
        chk("ps4_frozen", 64'(r4), 64'(frozen4[31:0]));
        chk("ps1_frozen", 64'(r1), 64'(frozen1[31:0]));

        // Carry from low to high half, then full 64-bit wrap.
        wr_word(6'd0, 4'b1111, 32'hFFFF_FFFF);
        wr_word(6'd1, 4'b1111, 32'h0);
        wr_word(6'd2, 4'b0001, 32'h1);
        idle(1);
        rd_word(6'd1);
        chk("carry_mtimeh", 64'(r1), 64'd1);
        wr_word(6'd2, 4'b0001, 32'h0);
        wr_word(6'd0, 4'b1111, 32'hFFFF_FFFF);
        wr_word(6'd1, 4'b1111, 32'hFFFF_FFFF);
        wr_word(6'd2, 4'b0001, 32'h1);
        idle(1);
        rd_word(6'd1);
        chk("wrap_mtimeh", 64'(r1), 64'd0);
        rd_word(6'd0);
        chk("wrap_mtimel", 64'(r1), 64'd1);

        // Compare channel 1 interrupt rise and fall.
        wr_word(6'd2, 4'b0001, 32'h0);
        wr_word(6'd0, 4'b1111, 32'h0);
        wr_word(6'd1, 4'b1111, 32'h0);
        wr_word(6'd6, 4'b0001, 32'h0000_0020);
        wr_word(6'd6, 4'b1111, 32'h0000_0020);
        wr_word(6'd7, 4'b1111, 32'h0);
        wr_word(6'd2, 4'b0001, 32'h1);
        idle(32);
        chk("irq1_before", 64'(b1.timer_irq_out[1]), 64'd0);
        step();
        chk("irq1_rise", 64'(b1.timer_irq_out[1]), 64'd1);
        chk("irq0_low", 64'(b1.timer_irq_out[0]), 64'd0);
        wr_word(6'd7, 4'b1111, 32'hFFFF_FFFF);
        chk("irq1_hold", 64'(b1.timer_irq_out[1]), 64'd1);
        step();
        chk("irq1_fall", 64'(b1.timer_irq_out[1]), 64'd0);

        // Software interrupt bits honour byte mask.
        wr_word(6'd3, 4'b0001, 32'h3);
        chk("msip_set", 64'(b1.soft_irq_out), 64'd3);
        wr_word(6'd3, 4'b0010, 32'h1);
        chk("msip_masked", 64'(b1.soft_irq_out), 64'd3);
        wr_word(6'd3, 4'b0001, 32'h0);
        chk("msip_clear", 64'(b1.soft_irq_out), 64'd0);

        // Write on a tick cycle wins over the increment.
        wr_word(6'd0, 4'b1111, 32'h0000_0100);
        rd_word(6'd0);
        chk("write_beats_tick_p1", 64'(r1), 64'h100);
        chk("write_beats_tick_p4", 64'(r4), 64'h100);

        // Reset in the middle of a read aborts it.
        wr_word(6'd3, 4'b0001, 32'h2);
        wr_word(6'd4, 4'b1111, 32'h1234_5678);
        t_addr  = {24'h0, 6'd4, 2'b00};
        t_sel   = 1'b1;
        t_read  = 1'b1;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        chk("abort_ready", 64'(b1.ready_out), 64'd0);
        t_sel   = 1'b0;
        t_read  = 1'b0;
        reset_n = 1'b1;
        step();
        chk("no_ack_after_release", 64'(b1.ready_out), 64'd0);
        rd_word(6'd2);
        chk("rst_ctrl", 64'(r1), 64'd1);
        rd_word(6'd3);
        chk("rst_msip", 64'(r1), 64'd0);
        rd_word(6'd4);
        chk("rst_cmpl0", 64'(r1), 64'hFFFF_FFFF);
        rd_word(6'd7);
        chk("rst_cmph1", 64'(r4), 64'hFFFF_FFFF);
        rd_word(6'd1);
        chk("rst_mtimeh", 64'(r1), 64'd0);

        // Random traffic, including unmapped words and back-to-back selects.
        for (int k = 0; k < 400; k++) begin
            rnd    = $urandom();
            t_sel  = rnd[0];
            t_read = rnd[1];
            t_mask = (rnd[4:2] < 3'd3) ? 4'b0000 : rnd[8:5];
            t_addr = {rnd[31:24], 16'h0, 6'($urandom_range(0, 9)), rnd[10:9]};
            t_data = (rnd[11]) ? $urandom() : {24'h0, rnd[23:16]};
            step();
        end
        t_sel  = 1'b0;
        t_read = 1'b0;
        t_mask = 4'b0000;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mtimer_multi.md
Name: mtimer_multi

Overview:
- Parametrised machine-timer peripheral on the CPU data bus: one free-running 64-bit mtime counter with prescaler, NUM_TIMERS independent 64-bit mtimecmp channels, per-channel level timer interrupt, per-channel software-interrupt bits.
- Replaces the single-compare timer. Unlike it, owns its own counter, honours 4-bit byte masks on a 32-bit bus, has a registered read path with ready, and drives interrupts.

Parameters:
- NUM_TIMERS, 2, number of compare channels / irq outputs (1..8).
- PRESCALE, 1, clk cycles per mtime increment (1..65535); 1 = every cycle.
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of every mtimecmp.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset_n  in  1  asynchronous active-low reset.
- address_in  in  32  byte address; only [7:2] decoded.
- sel_in  in  1  block selected this cycle.
- read_in  in  1  read request (qualified by sel_in).
- write_mask_in  in  4  byte enables; bit k covers write_value_in[8k+7:8k]; nonzero with sel_in = write.
- write_value_in  in  32  write data.
- read_value_out  out  32  read data, valid when ready_out=1, else 0.
- ready_out  out  1  one-cycle pulse acknowledging each selected access.
- timer_irq_out  out  NUM_TIMERS  level timer interrupt per channel.
- soft_irq_out  out  NUM_TIMERS  level software interrupt per channel (msip).

Behaviour:
- Word map (address_in[7:2]): 0 MTIMEL, 1 MTIMEH, 2 CTRL (bit0 enable, rest RAZ/WI), 3 MSIP (bits [NUM_TIMERS-1:0], rest RAZ/WI), 4+2i MTIMECMPL[i], 5+2i MTIMECMPH[i], i<NUM_TIMERS. Unmapped words read 0, writes ignored, still acked.
- Reset (async, reset_n=0): mtime=0, prescale count=0, CTRL.enable=1, msip=0, all mtimecmp=CMP_RESET, read_value_out=0, ready_out=0, timer_irq_out=0, soft_irq_out=0. Reset mid-access aborts it; no ack after release.
- Prescaler: counter 0..PRESCALE-1 counts when enable=1; tick when counter==PRESCALE-1, then wraps to 0. PRESCALE=1 ticks every enabled cycle. enable=0 freezes counter and mtime.
- mtime: +1 per tick, full 64-bit carry; 2^64-1 wraps to 0.
- Writes: byte-masked into addressed 32-bit half; unmasked bytes unchanged. Take effect at the posedge of the access.
- Write to MTIMEL/MTIMEH same cycle as a tick: write wins for the written half; unwritten bytes of that half hold old value (no increment this cycle); other half also not incremented. Prescale counter still advances.
- Read: sel_in&read_in captured; next cycle ready_out=1, read_value_out = value at the sampling posedge (pre-write, pre-tick). Write-only access: ready_out=1 next cycle, read_value_out=0.
- One access in flight max: a new sel_in while ready_out=1 is legal (back-to-back, one ack per select cycle). Bus holds sel_in for one cycle per access.
- timer_irq_out[i] registered: next-cycle value = (mtime >= mtimecmp[i]), unsigned 64-bit, evaluated on current-cycle register values. Independent of enable. Clears one cycle after mtimecmp[i] is raised above mtime.
- soft_irq_out = msip register, direct.
- Channels with i>=NUM_TIMERS do not exist; their words are unmapped.

Test Plan:
- Reset, no access, PRESCALE=1 -> after 10 cycles MTIMEL reads 10 (±read latency defined above), MTIMEH 0, all irq 0, ready_out one cycle after each read.
- PRESCALE=4: write CTRL=0, MTIMEL=0, CTRL=1, wait 16 cycles -> mtime advanced exactly 4; with CTRL=0 for 20 cycles -> unchanged.
- Write MTIMEL=FFFF_FFFF, MTIMEH=0 (enable=0), enable -> after one tick MTIMEH=1, MTIMEL=0; set mtime to all ones -> wraps to 0.
- Write MTIMECMPL[1]=0x0000_0020 mask 4'b0001 then 4'b1111 with 0x20, MTIMECMPH[1]=0 -> timer_irq_out[1] rises the cycle after mtime reaches 0x20, channel 0 stays low; rewrite cmp to 0xFFFF_FFFF hi -> irq falls next cycle.
- Write MSIP=0x3 mask 4'b0001 -> soft_irq_out=2'b11; write 0x1 mask 4'b0010 -> unchanged; write 0 mask 4'b0001 -> 0.
- Write MTIMEL=0x100 on a tick cycle -> reads 0x100, not 0x101; assert reset_n mid-read -> ready_out stays 0, all regs at reset values.
